// File: rtl/wb_write_queue.sv
// wb_write_queue
//   Writeback-side write queue that owns the register file's single write
//   port. Results from the memory-load path and the ALU path are buffered
//   in order in a circular FIFO and drained one per cycle into a registered
//   write stage (rf_we / rf_waddr / rf_wdata). Two combinational forwarding
//   ports let decode see values that are queued but not yet committed.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   mem_valid/mem_addr/mem_data   memory-load result (older instruction)
//   alu_valid/alu_addr/alu_data   ALU result (younger instruction)
//   stall                         fewer than 2 free entries; upstream holds
//   rf_we/rf_waddr/rf_wdata       registered register-file write request
//   fwd_addr1/fwd_addr2           forwarding lookup addresses
//   fwd_hit1/fwd_data1            port 1 lookup result (0/0 on miss)
//   fwd_hit2/fwd_data2            port 2 lookup result (0/0 on miss)
//   count                         queued entries, excluding the rf_* stage
//   overflow                      sticky: a valid input was dropped
module wb_write_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [ADDR_W-1:0]          fwd_addr1,
  input  logic [ADDR_W-1:0]          fwd_addr2,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              pop;
  logic [CNT_W-1:0]  free_after;
  logic [CNT_W-1:0]  alu_need;
  logic              take_mem;
  logic              take_alu;
  logic              drop;
  logic [CNT_W-1:0]  n_push;
  logic [PTR_W-1:0]  alu_slot;

  // Pointer advance; power-of-two depth makes the wrap implicit.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] n);
    return p + n;
  endfunction

  // Push/pop decisions; free space is judged after this edge's pop.
  always_comb begin
    pop        = (count != {CNT_W{1'b0}});
    free_after = CNT_W'(DEPTH) - count + CNT_W'(pop);
    take_mem   = mem_valid && (free_after >= CNT_W'(1'b1));
    // The load is older, so it claims the first slot; ALU needs the next one.
    alu_need   = take_mem ? CNT_W'(2'd2) : CNT_W'(1'b1);
    take_alu   = alu_valid && (free_after >= alu_need);
    drop       = (mem_valid && !take_mem) || (alu_valid && !take_alu);
    n_push     = CNT_W'(take_mem) + CNT_W'(take_alu);
    alu_slot   = ptr_add(tail, PTR_W'(take_mem));
  end

  assign stall = (CNT_W'(DEPTH) - count) < CNT_W'(2'd2);

  // Control state: pointers, occupancy, output write stage, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= {PTR_W{1'b0}};
      tail     <= {PTR_W{1'b0}};
      count    <= {CNT_W{1'b0}};
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= addr_q[head];
        rf_wdata <= data_q[head];
        head     <= ptr_add(head, PTR_W'(1'b1));
      end else begin
        rf_we    <= 1'b0;
      end
      tail  <= ptr_add(tail, n_push[PTR_W-1:0]);
      count <= count - CNT_W'(pop) + n_push;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage; stale contents are harmless because count gates every read.
  always_ff @(posedge clk) begin
    if (take_mem) begin
      addr_q[tail] <= mem_addr;
      data_q[tail] <= mem_data;
    end
    if (take_alu) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  logic [PTR_W-1:0] idx;
  logic             live;
  logic             m1;
  logic             m2;

  // Forwarding: scan oldest to newest so later matches override earlier ones,
  // leaving the newest pending write for each address.
  always_comb begin
    idx  = {PTR_W{1'b0}};
    live = 1'b0;
    m1   = rf_we && (rf_waddr == fwd_addr1);
    m2   = rf_we && (rf_waddr == fwd_addr2);
    fwd_hit1  = m1;
    fwd_data1 = m1 ? rf_wdata : {DATA_W{1'b0}};
    fwd_hit2  = m2;
    fwd_data2 = m2 ? rf_wdata : {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx  = ptr_add(head, PTR_W'(i));
      live = (CNT_W'(i) < count);
      m1   = live && (addr_q[idx] == fwd_addr1);
      m2   = live && (addr_q[idx] == fwd_addr2);
      fwd_hit1  = fwd_hit1 | m1;
      fwd_data1 = m1 ? data_q[idx] : fwd_data1;
      fwd_hit2  = fwd_hit2 | m2;
      fwd_data2 = m2 ? data_q[idx] : fwd_data2;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        stall;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  fwd_addr1;
  logic [2:0]  fwd_addr2;
  logic        fwd_hit1;
  logic [15:0] fwd_data1;
  logic        fwd_hit2;
  logic [15:0] fwd_data2;
  logic [2:0]  count;
  logic        overflow;

  int checks;
  int passed;

  wb_write_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_addr = 3'd0; mem_data = 16'h0000;
    alu_valid = 1'b0; alu_addr = 3'd0; alu_data = 16'h0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    fwd_addr1 = 3'd0; fwd_addr2 = 3'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %b exp 0", rf_we); else passed++;
    checks++; if (rf_waddr !== 3'd0) $display("FAIL reset_rf_waddr got %0d exp 0", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 16'h0000) $display("FAIL reset_rf_wdata got %h exp 0000", rf_wdata); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 16'h0000)
      $display("FAIL reset_fwd1 got %b/%h exp 0/0000", fwd_hit1, fwd_data1); else passed++;
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234;
    tick();
    idle_inputs();
    checks++; if (count !== 3'd1 || rf_we !== 1'b0)
      $display("FAIL single_queued got count=%0d we=%b exp 1/0", count, rf_we); else passed++;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234 || count !== 3'd0)
      $display("FAIL single_write got we=%b a=%0d d=%h c=%0d exp 1/3/1234/0", rf_we, rf_waddr, rf_wdata, count);
    else passed++;
    tick();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234)
      $display("FAIL single_after got we=%b a=%0d d=%h exp 0/3/1234", rf_we, rf_waddr, rf_wdata); else passed++;
  endtask

  task automatic test_dual_order();
    fwd_addr1 = 3'd2; fwd_addr2 = 3'd7;
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h5555;
    tick();
    idle_inputs();
    checks++; if (count !== 3'd2) $display("FAIL dual_count got %0d exp 2", count); else passed++;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h5555)
      $display("FAIL dual_fwd_newest got %b/%h exp 1/5555", fwd_hit1, fwd_data1); else passed++;
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0000)
      $display("FAIL dual_fwd_miss got %b/%h exp 0/0000", fwd_hit2, fwd_data2); else passed++;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'hAAAA)
      $display("FAIL dual_first got we=%b a=%0d d=%h exp 1/2/AAAA", rf_we, rf_waddr, rf_wdata); else passed++;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h5555)
      $display("FAIL dual_fwd_pending got %b/%h exp 1/5555", fwd_hit1, fwd_data1); else passed++;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h5555)
      $display("FAIL dual_second got we=%b a=%0d d=%h exp 1/2/5555", rf_we, rf_waddr, rf_wdata); else passed++;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h5555)
      $display("FAIL dual_fwd_rfstage got %b/%h exp 1/5555", fwd_hit1, fwd_data1); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_data1 !== 16'h0000)
      $display("FAIL dual_drained got we=%b hit=%b d=%h exp 0/0/0000", rf_we, fwd_hit1, fwd_data1); else passed++;
  endtask

  // Four dual pushes: counts go 2,3,4,4; the fourth loses its ALU half.
  task automatic fill_queue();
    logic [2:0] exp_cnt [4];
    exp_cnt[0] = 3'd2; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd4; exp_cnt[3] = 3'd4;
    for (int k = 1; k <= 4; k++) begin
      mem_valid = 1'b1; mem_addr = 3'(k);     mem_data = 16'h0A00 + 16'(k);
      alu_valid = 1'b1; alu_addr = 3'(k + 4); alu_data = 16'h0B00 + 16'(k);
      tick();
      checks++; if (count !== exp_cnt[k-1])
        $display("FAIL full_count_%0d got %0d exp %0d", k, count, exp_cnt[k-1]); else passed++;
      checks++; if (stall !== (k >= 2))
        $display("FAIL full_stall_%0d got %b exp %b", k, stall, (k >= 2)); else passed++;
      checks++; if (overflow !== (k == 4))
        $display("FAIL full_overflow_%0d got %b exp %b", k, overflow, (k == 4)); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_full_overflow();
    logic [2:0]  ea [7];
    logic [15:0] ed [7];
    ea[0] = 3'd1; ed[0] = 16'h0A01;
    ea[1] = 3'd5; ed[1] = 16'h0B01;
    ea[2] = 3'd2; ed[2] = 16'h0A02;
    ea[3] = 3'd6; ed[3] = 16'h0B02;
    ea[4] = 3'd3; ed[4] = 16'h0A03;
    ea[5] = 3'd7; ed[5] = 16'h0B03;
    ea[6] = 3'd4; ed[6] = 16'h0A04;
    fill_queue();
    // After the fourth push edge, rf already shows the third entry.
    checks++; if (rf_we !== 1'b1 || rf_waddr !== ea[2] || rf_wdata !== ed[2])
      $display("FAIL full_rf_2 got we=%b a=%0d d=%h exp 1/%0d/%h", rf_we, rf_waddr, rf_wdata, ea[2], ed[2]);
    else passed++;
    for (int j = 3; j < 7; j++) begin
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== ea[j] || rf_wdata !== ed[j])
        $display("FAIL full_rf_%0d got we=%b a=%0d d=%h exp 1/%0d/%h", j, rf_we, rf_waddr, rf_wdata, ea[j], ed[j]);
      else passed++;
    end
    tick();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0 || overflow !== 1'b1)
      $display("FAIL full_end got we=%b c=%0d ov=%b exp 0/0/1", rf_we, count, overflow); else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_addr = 3'(i % 8); alu_data = 16'((i % 8) * 16'h0111);
      tick();
      checks++; if (count !== 3'd1) $display("FAIL wrap_count_%0d got %0d exp 1", i, count); else passed++;
      if (i > 0) begin
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'((i - 1) % 8) || rf_wdata !== 16'(((i - 1) % 8) * 16'h0111))
          $display("FAIL wrap_rf_%0d got we=%b a=%0d d=%h", i - 1, rf_we, rf_waddr, rf_wdata);
        else passed++;
      end
    end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 16'h0111)
      $display("FAIL wrap_rf_9 got we=%b a=%0d d=%h exp 1/1/0111", rf_we, rf_waddr, rf_wdata); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0 || overflow !== 1'b0 || count !== 3'd0)
      $display("FAIL wrap_end got we=%b ov=%b c=%0d exp 0/0/0", rf_we, overflow, count); else passed++;
  endtask

  task automatic test_fwd_output_stage();
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'hBEEF;
    tick();
    idle_inputs();
    fwd_addr1 = 3'd6; fwd_addr2 = 3'd5;
    tick();
    checks++; if (rf_we !== 1'b1 || count !== 3'd0)
      $display("FAIL fwdo_stage got we=%b c=%0d exp 1/0", rf_we, count); else passed++;
    checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 16'hBEEF)
      $display("FAIL fwdo_hit2 got %b/%h exp 1/BEEF", fwd_hit2, fwd_data2); else passed++;
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 16'h0000)
      $display("FAIL fwdo_miss1 got %b/%h exp 0/0000", fwd_hit1, fwd_data1); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    fill_queue();
    tick();
    checks++; if (count !== 3'd3 || overflow !== 1'b1)
      $display("FAIL rstmid_pre got c=%0d ov=%b exp 3/1", count, overflow); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || rf_we !== 1'b0 || overflow !== 1'b0 || stall !== 1'b0)
      $display("FAIL rstmid_post got c=%0d we=%b ov=%b st=%b exp 0/0/0/0", count, rf_we, overflow, stall);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || count !== 3'd0)
        $display("FAIL rstmid_quiet_%0d got we=%b c=%0d exp 0/0", i, rf_we, count); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    idle_inputs();
    fwd_addr1 = 3'd0; fwd_addr2 = 3'd0;
    test_reset();
    test_single();
    test_dual_order();
    test_full_overflow();
    test_reset();
    test_wrap();
    test_fwd_output_stage();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
